// File: rtl/wb_gain_stage.sv
// Per-phase white-balance gain stage for a Bayer Avalon-ST stream.
// Three-stage pipeline (select, multiply, round/saturate) with frame-atomic gain banks.
module wb_gain_stage #(
  parameter int unsigned DW   = 8,
  parameter int unsigned W    = 1920,
  parameter int unsigned H    = 1080,
  parameter int unsigned GW   = 18,
  parameter int unsigned FRAC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     sink_data,
  input  logic              sink_valid,
  input  logic              sink_sop,
  input  logic              sink_eop,
  output logic              sink_ready,
  output logic [DW-1:0]     source_data,
  output logic              source_valid,
  output logic              source_sop,
  output logic              source_eop,
  input  logic              source_ready,
  input  logic [4*GW-1:0]   cfg_gain,
  input  logic              cfg_update,
  input  logic [1:0]        cfg_pattern,
  input  logic              cfg_bypass,
  output logic              size_err,
  output logic              frame_done
);

  localparam int unsigned XW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned YW = $clog2(H + 1);
  localparam int unsigned PW = DW + GW;
  localparam int unsigned RW = PW + 1;

  localparam logic [GW-1:0] UNITY = GW'(1 << FRAC);
  localparam logic [RW-1:0] HALF  = RW'(1 << (FRAC - 1));
  localparam logic [RW-1:0] MAXV  = RW'((1 << DW) - 1);

  logic                  w_en;
  logic                  w_acc;
  logic                  w_sop_acc;
  logic                  w_pix;
  logic                  w_eop_pix;
  logic                  w_last;
  logic [1:0]            w_idx;
  logic [GW-1:0]         w_gain;
  logic [RW-1:0]         w_res;
  logic [DW-1:0]         w_sat;

  logic                  r_in_pkt;
  logic [XW-1:0]         r_x_cnt;
  logic [YW-1:0]         r_y_cnt;
  logic [3:0][GW-1:0]    r_pending;
  logic [3:0][GW-1:0]    r_active;

  logic                  r1_valid, r1_sop, r1_eop, r1_pass;
  logic [DW-1:0]         r1_data;
  logic [GW-1:0]         r1_gain;
  logic                  r2_valid, r2_sop, r2_eop, r2_pass;
  logic [DW-1:0]         r2_data;
  logic [PW-1:0]         r2_prod;

  // Whole pipeline advances together; a stalled output freezes every stage.
  assign w_en       = !source_valid || source_ready;
  assign sink_ready = w_en;
  assign w_acc      = sink_valid && w_en;
  assign w_sop_acc  = w_acc && sink_sop;
  assign w_pix      = w_acc && !sink_sop && r_in_pkt;
  assign w_eop_pix  = w_pix && sink_eop;
  assign w_last     = (r_x_cnt == XW'(W - 1)) && (r_y_cnt == YW'(H - 1));
  assign w_idx      = {r_y_cnt[0], r_x_cnt[0]} ^ cfg_pattern;
  assign w_gain     = r_active[w_idx];

  assign frame_done = !rst && w_eop_pix;
  assign size_err   = !rst && w_eop_pix && !w_last;

  // Round half up, then clamp to the pixel range.
  assign w_res = (RW'(r2_prod) + HALF) >> FRAC;
  assign w_sat = (w_res > MAXV) ? {DW{1'b1}} : DW'(w_res);

  // Gain banks: active only reloads on an accepted header beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= {4{UNITY}};
      r_active  <= {4{UNITY}};
    end else begin
      if (cfg_update) begin
        r_pending <= cfg_gain;
      end
      if (w_sop_acc) begin
        r_active <= cfg_update ? cfg_gain : r_pending;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_pkt <= 1'b0;
      r_x_cnt  <= '0;
      r_y_cnt  <= '0;
    end else if (w_sop_acc) begin
      r_in_pkt <= 1'b1;
      r_x_cnt  <= '0;
      r_y_cnt  <= '0;
    end else if (w_pix) begin
      if (sink_eop) begin
        r_in_pkt <= 1'b0;
        r_x_cnt  <= '0;
        r_y_cnt  <= '0;
      end else if (r_x_cnt == XW'(W - 1)) begin
        r_x_cnt <= '0;
        r_y_cnt <= r_y_cnt + YW'(1);
      end else begin
        r_x_cnt <= r_x_cnt + XW'(1);
      end
    end
  end

  // Stage 1 latches beat and phase gain, stage 2 multiplies, stage 3 drives the source.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid     <= 1'b0;
      r1_sop       <= 1'b0;
      r1_eop       <= 1'b0;
      r1_pass      <= 1'b0;
      r1_data      <= '0;
      r1_gain      <= '0;
      r2_valid     <= 1'b0;
      r2_sop       <= 1'b0;
      r2_eop       <= 1'b0;
      r2_pass      <= 1'b0;
      r2_data      <= '0;
      r2_prod      <= '0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_data  <= '0;
    end else if (w_en) begin
      r1_valid     <= w_sop_acc || w_pix;
      r1_sop       <= sink_sop;
      r1_eop       <= sink_eop;
      r1_pass      <= cfg_bypass || sink_sop;
      r1_data      <= sink_data;
      r1_gain      <= w_gain;
      r2_valid     <= r1_valid;
      r2_sop       <= r1_sop;
      r2_eop       <= r1_eop;
      r2_pass      <= r1_pass;
      r2_data      <= r1_data;
      r2_prod      <= PW'(r1_data) * PW'(r1_gain);
      source_valid <= r2_valid;
      source_sop   <= r2_sop;
      source_eop   <= r2_eop;
      source_data  <= r2_pass ? r2_data : w_sat;
    end
  end

endmodule

// File: tb/tb_wb_gain_stage.sv
// Directed bench for wb_gain_stage on a 4x2 frame with hand-computed pixel values.
module tb_wb_gain_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sink_data;
  logic        sink_valid, sink_sop, sink_eop, sink_ready;
  logic [7:0]  source_data;
  logic        source_valid, source_sop, source_eop, source_ready;
  logic [71:0] cfg_gain;
  logic        cfg_update, cfg_bypass;
  logic [1:0]  cfg_pattern;
  logic        size_err, frame_done;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int se_cnt = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int out_cyc = 0;
  logic rand_rdy = 1'b0;
  logic stall_prev = 1'b0;
  logic [10:0] stall_val;
  logic [9:0] rx_q[$];
  logic [9:0] exp_q[$];

  wb_gain_stage #(.DW(8), .W(4), .H(2), .GW(18), .FRAC(8)) dut (
    .clk(clk), .rst(rst),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop),
    .sink_eop(sink_eop), .sink_ready(sink_ready),
    .source_data(source_data), .source_valid(source_valid), .source_sop(source_sop),
    .source_eop(source_eop), .source_ready(source_ready),
    .cfg_gain(cfg_gain), .cfg_update(cfg_update), .cfg_pattern(cfg_pattern),
    .cfg_bypass(cfg_bypass), .size_err(size_err), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: samples on the falling edge, between driver updates.
  always @(negedge clk) begin
    if (!rst) begin
      chk("sink_ready_en", 32'(sink_ready), 32'(!source_valid || source_ready));
      if (stall_prev)
        chk("stall_hold", 32'({source_valid, source_sop, source_eop, source_data}), 32'(stall_val));
      stall_prev = source_valid && !source_ready;
      stall_val  = {source_valid, source_sop, source_eop, source_data};
      if (source_valid && source_ready) rx_q.push_back({source_sop, source_eop, source_data});
      if (frame_done) fd_cnt++;
      if (size_err) se_cnt++;
      if (sink_valid && sink_ready && sink_sop) acc_cyc = cyc;
      if (source_valid && source_ready && source_sop) out_cyc = cyc;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      source_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic s, input logic e);
    sink_data = d; sink_sop = s; sink_eop = e; sink_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (sink_ready) begin
        tick();
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        return;
      end
      tick();
    end
    errors++;
    $display("FAIL send_timeout observed=stalled expected=accepted");
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
  endtask

  task automatic send_frame8(input logic [7:0] hdr, input logic [7:0] px[8]);
    send(hdr, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send(px[i], 1'b0, i == 7);
  endtask

  task automatic add_frame8(input logic [7:0] hdr, input logic [7:0] ev[8]);
    exp_q.push_back({1'b1, 1'b0, hdr});
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, i == 7, ev[i]});
  endtask

  task automatic set_gains(input logic [17:0] g0, g1, g2, g3);
    cfg_gain = {g3, g2, g1, g0};
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
  endtask

  task automatic expect_frames(input string tag);
    int n;
    n = exp_q.size();
    for (int t = 0; t < 600 && rx_q.size() < n; t++) tick();
    repeat (6) tick();
    chk({tag, "_len"}, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] px[8];
    logic [7:0] ev[8];
    rst = 1'b1; sink_data = '0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    source_ready = 1'b1; cfg_gain = {4{18'h100}}; cfg_update = 1'b0;
    cfg_pattern = 2'b00; cfg_bypass = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(source_valid), 0);
    chk("rst_sop", 32'(source_sop), 0);
    chk("rst_eop", 32'(source_eop), 0);
    chk("rst_data", 32'(source_data), 0);
    chk("rst_fd", 32'(frame_done), 0);
    chk("rst_se", 32'(size_err), 0);
    rst = 1'b0;
    tick();

    // Unity pass-through and latency
    for (int i = 0; i < 8; i++) px[i] = 8'(8'h10 + i);
    fd_cnt = 0; se_cnt = 0;
    send_frame8(8'hA5, px);
    add_frame8(8'hA5, px);
    expect_frames("unity");
    chk("latency", 32'(out_cyc - acc_cyc), 3);
    chk("unity_fd", 32'(fd_cnt), 1);
    chk("unity_se", 32'(se_cnt), 0);

    // Per-phase gains
    set_gains(18'h180, 18'h100, 18'h100, 18'h080);
    px = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
    ev = '{8'h60, 8'h40, 8'h60, 8'h40, 8'h40, 8'h20, 8'h40, 8'h20};
    send_frame8(8'h01, px);
    add_frame8(8'h01, ev);
    expect_frames("phase");

    // Saturation and rounding
    set_gains(18'h200, 18'h080, 18'h100, 18'h100);
    px = '{8'hC8, 8'h03, 8'h11, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04};
    ev = '{8'hFF, 8'h02, 8'h22, 8'h80, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame8(8'h02, px);
    add_frame8(8'h02, ev);
    expect_frames("satrnd");

    // Mid-frame update must wait for the next header
    send(8'h03, 1'b1, 1'b0);
    send(8'h10, 1'b0, 1'b0);
    send(8'h10, 1'b0, 1'b0);
    set_gains(18'h100, 18'h100, 18'h100, 18'h100);
    for (int i = 2; i < 8; i++) send(8'h10, 1'b0, i == 7);
    ev = '{8'h20, 8'h08, 8'h20, 8'h08, 8'h10, 8'h10, 8'h10, 8'h10};
    add_frame8(8'h03, ev);
    expect_frames("midupd");
    px = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
    send_frame8(8'h04, px);
    add_frame8(8'h04, px);
    expect_frames("nextsop");

    // Update coincident with the header applies to that frame
    cfg_gain = {4{18'h200}};
    cfg_update = 1'b1;
    send(8'h05, 1'b1, 1'b0);
    cfg_update = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h10, 1'b0, i == 7);
    ev = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
    add_frame8(8'h05, ev);
    expect_frames("sopupd");

    // Bypass ignores the 2x gains
    cfg_bypass = 1'b1;
    send_frame8(8'h06, px);
    add_frame8(8'h06, px);
    expect_frames("bypass");
    cfg_bypass = 1'b0;

    // Random backpressure across two frames
    rand_rdy = 1'b1;
    fd_cnt = 0;
    for (int i = 0; i < 8; i++) px[i] = 8'(i + 1);
    for (int i = 0; i < 8; i++) ev[i] = 8'(2 * (i + 1));
    send_frame8(8'h07, px);
    send_frame8(8'h08, px);
    add_frame8(8'h07, ev);
    add_frame8(8'h08, ev);
    expect_frames("bp");
    rand_rdy = 1'b0;
    tick();
    chk("bp_fd", 32'(fd_cnt), 2);

    // Short frame flags size_err but still forwards beats
    fd_cnt = 0; se_cnt = 0;
    send(8'h09, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send(8'(i + 1), 1'b0, i == 4);
    exp_q.push_back({2'b10, 8'h09});
    for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, i == 4, 8'(2 * (i + 1))});
    expect_frames("short");
    chk("short_se", 32'(se_cnt), 1);
    chk("short_fd", 32'(fd_cnt), 1);

    // Pixels outside a packet are dropped
    for (int i = 0; i < 3; i++) send(8'h77, 1'b0, 1'b0);
    expect_frames("orphan");

    // Reset mid-frame flushes the pipe and restores unity gains
    send(8'h0A, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send(8'h50, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(source_valid), 1);
    rst = 1'b1;
    tick();
    chk("post_rst_valid", 32'(source_valid), 0);
    rst = 1'b0;
    rx_q.delete();
    tick();
    for (int i = 0; i < 8; i++) px[i] = 8'(8'h30 + i);
    send_frame8(8'h0B, px);
    add_frame8(8'h0B, px);
    expect_frames("after_rst");

    // Pattern 11 moves the phase-0 gain to odd column of odd row
    set_gains(18'h200, 18'h100, 18'h100, 18'h100);
    cfg_pattern = 2'b11;
    px = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
    ev = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h20, 8'h10, 8'h20};
    send_frame8(8'h0C, px);
    add_frame8(8'h0C, ev);
    expect_frames("pattern");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
